mealy_fsm_engine: RTL and testbench
===================================

# mealy_fsm_engine

Table-driven, parametrised Mealy state machine with a built-in conformance checker. Software or a testbench loads the transition/output table through a configuration port. The engine then steps one transition per `step` pulse and, when enabled, compares each transition against expected next-state and output values, counting mismatches. It generalises the fixed 3-state, 2-bit-input FSM check block to arbitrary state count and input/output widths.

## Interface
- `N_STATES`, 3: number of legal states (2..256); `SW = max(1, clog2(N_STATES))`
- `IN_W`, 2: input symbol width (1..6)
- `OUT_W`, 4: Mealy output width (1..32)
- `RESET_STATE`, 0: state after reset; also the clamp target for illegal next-states
- `CNT_W`, 8: mismatch counter width
- `clk`, in, 1: single clock, rising edge
- `reset`, in, 1: synchronous, active-high reset
- `cfg_we`, in, 1: table write strobe
- `cfg_addr`, in, SW+IN_W: table index `{state, in}`
- `cfg_ns`, in, SW: next-state field to write
- `cfg_out`, in, OUT_W: output field to write
- `step`, in, 1: advance one transition this cycle
- `in`, in, IN_W: input symbol
- `state`, out, SW: registered current state
- `next_state`, out, SW: combinational looked-up next state (after clamp)
- `out`, out, OUT_W: combinational Mealy output for `{state, in}`
- `chk_en`, in, 1: compare this step against expectations
- `exp_ns`, in, SW: expected next state
- `exp_out`, in, OUT_W: expected output
- `mismatch`, out, 1: combinational; `step & chk_en & (next_state != exp_ns | out != exp_out)`
- `err_cnt`, out, CNT_W: saturating mismatch count
- `err_sticky`, out, 1: set on first mismatch
- `err_state`, out, SW: `state` at first mismatch
- `err_in`, out, IN_W: `in` at first mismatch
- `illegal`, out, 1: sticky; a step looked up a next-state field ≥ N_STATES
- `err_clr`, in, 1: clears `err_cnt`, `err_sticky`, `err_state`, `err_in`, `illegal`

## Operation
- Table: `N_STATES * 2^IN_W` entries of `{ns[SW], out[OUT_W]}`, indexed `state*2^IN_W + in`.
- Reset: every entry becomes `{RESET_STATE, 0}`. `state = RESET_STATE`. `err_cnt = 0`; `err_sticky`, `illegal` = 0; `err_state`, `err_in` = 0.
- Write: when `cfg_we` is high, the entry at `cfg_addr` is updated at the clock edge. Writes with a state field ≥ N_STATES are ignored. Writes are allowed while stepping.
- Lookup is combinational from `state` and `in`. `out` and `next_state` are valid every cycle, independent of `step`.
- Clamp: if the stored ns ≥ N_STATES, `next_state = RESET_STATE`. If `step` is also high, `illegal` is set.
- Step: on `step`, `state <= next_state`. Without `step`, `state` holds.
- Checker: on `mismatch`, `err_cnt` increments, saturating at `2^CNT_W-1`, and `err_sticky` is set. `err_state`/`err_in` capture only when `err_sticky` was 0 before the edge.
- `err_clr` and `mismatch` in the same cycle: `err_clr` wins for the count, so `err_cnt = 0`. The new mismatch is not counted.
- `reset` overrides everything, including `cfg_we` and `step`.

## Timing
- Lookup latency 0 cycles; state-update latency 1 cycle.
- Write and read of the same entry in the same cycle: the lookup sees the old contents. The new contents are visible from the next cycle.
- A write to the entry currently addressed changes `out`/`next_state` in the cycle after the write edge. No glitch constraints beyond synchronous design.
- `err_cnt`, `err_sticky`, `illegal` update at the edge following the offending step.
- Reset mid-run: the table, state and checker are all reinitialised in one cycle. All outputs reflect reset values from the cycle after `reset` is sampled high.

## Test plan
- **Reset defaults.** Assert `reset` 1 cycle, then `in=2`, `step=1`. Required: `state=0`, `out=0`, `next_state=0`, `err_cnt=0`.
- **3-state walk.** Program a 3-state table: (0,1)->{1,4'hA}, (1,2)->{2,4'h5}, (2,0)->{0,4'hF}. Step with `in` = 1, 2, 0. Required: states 1, 2, 0; `out` = A, 5, F in the respective step cycles.
- **Checker.** With `chk_en=1`, give one wrong `exp_out` at state 1/in 2. Required: `mismatch=1` in that cycle, `err_cnt=1`, `err_sticky=1`, `err_state=1`, `err_in=2`. A second mismatch gives `err_cnt=2`, with `err_state`/`err_in` unchanged. Force 300 mismatches with CNT_W=8: `err_cnt` saturates at 255.
- **Illegal next-state.** Use `N_STATES=3`, SW=2. Write ns=3 at (0,0) and step with `in=0`. Required: `next_state=0`, `illegal=1`, `state=0`. A write with `cfg_addr` state field = 3 is ignored.
- **Write/step collision.** In the same cycle as `step` at (0,1), write (0,1)->{2,4'h3}. Required: that step uses the old entry (`state` becomes 1). The next lookup of (0,1) returns {2,3}.
- **Clear vs. reset.** With `err_clr` and `mismatch` both high, `err_cnt=0` next cycle. With `reset` mid-walk, `state=0` and the table reads `{0,0}` next cycle.

Source files
------------

// File: rtl/mealy_fsm_engine.sv
// Table-driven Mealy state machine with a loadable transition/output table and a
// conformance checker that counts steps disagreeing with supplied expectations.
module mealy_fsm_engine #(
  parameter int unsigned N_STATES    = 3,
  parameter int unsigned IN_W        = 2,
  parameter int unsigned OUT_W       = 4,
  parameter int unsigned RESET_STATE = 0,
  parameter int unsigned CNT_W       = 8,
  localparam int unsigned SW         = (N_STATES > 2) ? $clog2(N_STATES) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_we,
  input  logic [SW+IN_W-1:0]   cfg_addr,
  input  logic [SW-1:0]        cfg_ns,
  input  logic [OUT_W-1:0]     cfg_out,
  input  logic                 step,
  input  logic [IN_W-1:0]      in,
  output logic [SW-1:0]        state,
  output logic [SW-1:0]        next_state,
  output logic [OUT_W-1:0]     out,
  input  logic                 chk_en,
  input  logic [SW-1:0]        exp_ns,
  input  logic [OUT_W-1:0]     exp_out,
  output logic                 mismatch,
  output logic [CNT_W-1:0]     err_cnt,
  output logic                 err_sticky,
  output logic [SW-1:0]        err_state,
  output logic [IN_W-1:0]      err_in,
  output logic                 illegal,
  input  logic                 err_clr
);

  localparam int unsigned AW    = SW + IN_W;
  localparam int unsigned Depth = 1 << AW;
  localparam logic [SW-1:0] RstSt = SW'(RESET_STATE);

  // Table spans the full address space; rows of states >= N_STATES are never written.
  logic [SW-1:0]    tbl_ns_q  [Depth];
  logic [SW-1:0]    tbl_ns_d  [Depth];
  logic [OUT_W-1:0] tbl_out_q [Depth];
  logic [OUT_W-1:0] tbl_out_d [Depth];

  logic [SW-1:0]    state_q, state_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_sticky_q, err_sticky_d;
  logic [SW-1:0]    err_state_q, err_state_d;
  logic [IN_W-1:0]  err_in_q, err_in_d;
  logic             illegal_q, illegal_d;

  logic [AW-1:0]    lu_idx;
  logic [SW-1:0]    lu_ns;
  logic             lu_bad;
  logic             cfg_ok;

  assign lu_idx     = {state_q, in};
  assign lu_ns      = tbl_ns_q[lu_idx];
  assign lu_bad     = 32'(lu_ns) >= N_STATES;
  assign next_state = lu_bad ? RstSt : lu_ns;
  assign out        = tbl_out_q[lu_idx];
  assign cfg_ok     = 32'(cfg_addr[AW-1:IN_W]) < N_STATES;
  assign mismatch   = step & chk_en & ((next_state != exp_ns) | (out != exp_out));

  always_comb begin
    tbl_ns_d  = tbl_ns_q;
    tbl_out_d = tbl_out_q;
    if (cfg_we && cfg_ok) begin
      tbl_ns_d[cfg_addr]  = cfg_ns;
      tbl_out_d[cfg_addr] = cfg_out;
    end
  end

  always_comb begin
    state_d      = step ? next_state : state_q;
    err_cnt_d    = err_cnt_q;
    err_sticky_d = err_sticky_q;
    err_state_d  = err_state_q;
    err_in_d     = err_in_q;
    illegal_d    = illegal_q;
    if (err_clr) begin
      // Clear takes priority over a coincident mismatch or illegal lookup.
      err_cnt_d    = '0;
      err_sticky_d = 1'b0;
      err_state_d  = '0;
      err_in_d     = '0;
      illegal_d    = 1'b0;
    end else begin
      if (mismatch) begin
        if (err_cnt_q != '1) begin
          err_cnt_d = err_cnt_q + CNT_W'(1);
        end
        if (!err_sticky_q) begin
          err_state_d = state_q;
          err_in_d    = in;
        end
        err_sticky_d = 1'b1;
      end
      if (step && lu_bad) begin
        illegal_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(Depth); i++) begin
        tbl_ns_q[i]  <= RstSt;
        tbl_out_q[i] <= '0;
      end
      state_q      <= RstSt;
      err_cnt_q    <= '0;
      err_sticky_q <= 1'b0;
      err_state_q  <= '0;
      err_in_q     <= '0;
      illegal_q    <= 1'b0;
    end else begin
      tbl_ns_q     <= tbl_ns_d;
      tbl_out_q    <= tbl_out_d;
      state_q      <= state_d;
      err_cnt_q    <= err_cnt_d;
      err_sticky_q <= err_sticky_d;
      err_state_q  <= err_state_d;
      err_in_q     <= err_in_d;
      illegal_q    <= illegal_d;
    end
  end

  assign state      = state_q;
  assign err_cnt    = err_cnt_q;
  assign err_sticky = err_sticky_q;
  assign err_state  = err_state_q;
  assign err_in     = err_in_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_mealy_fsm_engine.sv
// Bench for mealy_fsm_engine: directed scenarios plus randomized traffic, all checked
// against an array-based model of the table, current state and error bookkeeping.
module tb_mealy_fsm_engine;

  localparam int N_STATES = 3;
  localparam int IN_W     = 2;
  localparam int OUT_W    = 4;
  localparam int CNT_W    = 8;
  localparam int SW       = 2;
  localparam int CNT_MAX  = 255;

  logic             clk = 1'b0;
  logic             reset, cfg_we, step, chk_en, err_clr;
  logic [SW+IN_W-1:0] cfg_addr;
  logic [SW-1:0]    cfg_ns, exp_ns, state, next_state, err_state;
  logic [OUT_W-1:0] cfg_out, exp_out, out;
  logic [IN_W-1:0]  in, err_in;
  logic             mismatch, err_sticky, illegal;
  logic [CNT_W-1:0] err_cnt;

  int n_cmp = 0;
  int n_err = 0;

  int m_ns [12];
  int m_out[12];
  int m_st, m_cnt, m_sticky, m_estate, m_ein, m_ill;

  always #5 clk = ~clk;

  mealy_fsm_engine #(
    .N_STATES   (N_STATES),
    .IN_W       (IN_W),
    .OUT_W      (OUT_W),
    .RESET_STATE(0),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_ns    (cfg_ns),
    .cfg_out   (cfg_out),
    .step      (step),
    .in        (in),
    .state     (state),
    .next_state(next_state),
    .out       (out),
    .chk_en    (chk_en),
    .exp_ns    (exp_ns),
    .exp_out   (exp_out),
    .mismatch  (mismatch),
    .err_cnt   (err_cnt),
    .err_sticky(err_sticky),
    .err_state (err_state),
    .err_in    (err_in),
    .illegal   (illegal),
    .err_clr   (err_clr)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_raw();
    return m_ns[m_st * 4 + int'(in)];
  endfunction

  function automatic int m_next();
    return (m_raw() >= N_STATES) ? 0 : m_raw();
  endfunction

  function automatic int m_outv();
    return m_out[m_st * 4 + int'(in)];
  endfunction

  function automatic int m_mis();
    return (step && chk_en && (m_next() != int'(exp_ns) || m_outv() != int'(exp_out))) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 12; i++) begin
      m_ns[i]  = 0;
      m_out[i] = 0;
    end
    m_st = 0; m_cnt = 0; m_sticky = 0; m_estate = 0; m_ein = 0; m_ill = 0;
  endtask

  task automatic model_edge();
    int raw, nxt, mis;
    if (reset) begin
      model_reset();
      return;
    end
    raw = m_raw();
    nxt = m_next();
    mis = m_mis();
    if (err_clr) begin
      m_cnt = 0; m_sticky = 0; m_estate = 0; m_ein = 0; m_ill = 0;
    end else begin
      if (mis != 0) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        if (m_sticky == 0) begin
          m_estate = m_st;
          m_ein    = int'(in);
        end
        m_sticky = 1;
      end
      if (step && raw >= N_STATES) m_ill = 1;
    end
    if (step) m_st = nxt;
    if (cfg_we && (int'(cfg_addr) / 4) < N_STATES) begin
      m_ns[int'(cfg_addr)]  = int'(cfg_ns);
      m_out[int'(cfg_addr)] = int'(cfg_out);
    end
  endtask

  // One clock: combinational outputs before the edge, registered outputs after it.
  task automatic cycle();
    #1;
    check_eq("out", 64'(out), 64'(m_outv()));
    check_eq("next_state", 64'(next_state), 64'(m_next()));
    check_eq("mismatch", 64'(mismatch), 64'(m_mis()));
    @(posedge clk);
    model_edge();
    #1;
    check_eq("state", 64'(state), 64'(m_st));
    check_eq("err_cnt", 64'(err_cnt), 64'(m_cnt));
    check_eq("err_sticky", 64'(err_sticky), 64'(m_sticky));
    check_eq("err_state", 64'(err_state), 64'(m_estate));
    check_eq("err_in", 64'(err_in), 64'(m_ein));
    check_eq("illegal", 64'(illegal), 64'(m_ill));
  endtask

  task automatic wr(input int s, input int i, input int ns, input int o);
    cfg_we   = 1'b1;
    cfg_addr = 4'(s * 4 + i);
    cfg_ns   = 2'(ns);
    cfg_out  = 4'(o);
    step     = 1'b0;
    chk_en   = 1'b0;
    cycle();
    cfg_we   = 1'b0;
  endtask

  task automatic step_to(input int i, input int want_st, input int want_out);
    in   = 2'(i);
    step = 1'b1;
    #1;
    check_eq("walk_out", 64'(out), 64'(want_out));
    cycle();
    check_eq("walk_state", 64'(state), 64'(want_st));
    step = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_ns = '0; cfg_out = '0;
    step = 1'b0; in = '0; chk_en = 1'b0; exp_ns = '0; exp_out = '0; err_clr = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset defaults
    in = 2'd2; step = 1'b1;
    #1;
    check_eq("rst_state", 64'(state), 64'd0);
    check_eq("rst_out", 64'(out), 64'd0);
    check_eq("rst_next", 64'(next_state), 64'd0);
    check_eq("rst_err_cnt", 64'(err_cnt), 64'd0);
    cycle();
    step = 1'b0;

    // 3-state walk
    wr(0, 1, 1, 'hA);
    wr(1, 2, 2, 'h5);
    wr(2, 0, 0, 'hF);
    step_to(1, 1, 'hA);
    step_to(2, 2, 'h5);
    step_to(0, 0, 'hF);

    // Checker: first and second mismatch, then saturation
    step_to(1, 1, 'hA);
    in = 2'd2; step = 1'b1; chk_en = 1'b1; exp_ns = 2'd2; exp_out = 4'h4;
    #1;
    check_eq("chk_mismatch", 64'(mismatch), 64'd1);
    cycle();
    check_eq("chk_cnt1", 64'(err_cnt), 64'd1);
    check_eq("chk_sticky", 64'(err_sticky), 64'd1);
    check_eq("chk_estate", 64'(err_state), 64'd1);
    check_eq("chk_ein", 64'(err_in), 64'd2);
    in = 2'd0; exp_ns = 2'd0; exp_out = 4'h0;
    cycle();
    check_eq("chk_cnt2", 64'(err_cnt), 64'd2);
    check_eq("chk_estate2", 64'(err_state), 64'd1);
    check_eq("chk_ein2", 64'(err_in), 64'd2);
    wr(0, 3, 0, 'h1);
    in = 2'd3; step = 1'b1; chk_en = 1'b1; exp_ns = 2'd0; exp_out = 4'h0;
    for (int k = 0; k < 300; k++) cycle();
    check_eq("chk_saturate", 64'(err_cnt), 64'd255);

    // Clear beats a coincident mismatch
    err_clr = 1'b1;
    #1;
    check_eq("clr_mismatch", 64'(mismatch), 64'd1);
    cycle();
    check_eq("clr_cnt", 64'(err_cnt), 64'd0);
    check_eq("clr_sticky", 64'(err_sticky), 64'd0);
    err_clr = 1'b0; chk_en = 1'b0; step = 1'b0;

    // Illegal next-state field is clamped and flagged
    wr(0, 0, 3, 'h7);
    in = 2'd0; step = 1'b1;
    #1;
    check_eq("ill_next", 64'(next_state), 64'd0);
    cycle();
    check_eq("ill_flag", 64'(illegal), 64'd1);
    check_eq("ill_state", 64'(state), 64'd0);
    wr(3, 0, 1, 'h9);
    in = 2'd0;
    #1;
    check_eq("ill_wr_ignored", 64'(out), 64'h7);

    // Write/step collision on the addressed entry
    in = 2'd1; step = 1'b1; cfg_we = 1'b1; cfg_addr = 4'd1; cfg_ns = 2'd2; cfg_out = 4'h3;
    cycle();
    check_eq("coll_state", 64'(state), 64'd1);
    cfg_we = 1'b0;
    step_to(2, 2, 'h5);
    step_to(0, 0, 'hF);
    in = 2'd1;
    #1;
    check_eq("coll_out", 64'(out), 64'h3);
    check_eq("coll_next", 64'(next_state), 64'd2);

    // Reset mid-walk wipes the table and state
    step = 1'b1; reset = 1'b1;
    cycle();
    reset = 1'b0; step = 1'b0;
    #1;
    check_eq("mid_rst_state", 64'(state), 64'd0);
    check_eq("mid_rst_out", 64'(out), 64'd0);
    check_eq("mid_rst_next", 64'(next_state), 64'd0);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      reset    = ($urandom_range(0, 199) == 0);
      cfg_we   = ($urandom_range(0, 2) == 0);
      cfg_addr = 4'($urandom);
      cfg_ns   = 2'($urandom);
      cfg_out  = 4'($urandom);
      step     = 1'($urandom);
      in       = 2'($urandom);
      chk_en   = 1'($urandom);
      err_clr  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 0) begin
        exp_ns  = 2'(m_next());
        exp_out = 4'(m_outv());
      end else begin
        exp_ns  = 2'($urandom);
        exp_out = 4'($urandom);
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
